// File: rtl/periph_bus_v2_pkg.sv
// Shared definitions for the data-side peripheral bus.
//
// Contents:
//   DM_OP_*        load/store operation codes carried on dm_op
//   *_BASE_DEF     default addr[31:16] values for the three regions
//   GPIO_OFF_*     GPIO register offsets (addr[7:0])
//   region_e       decoded target of an access
//   helpers        op legality, alignment and GPIO offset classification
package periph_bus_v2_pkg;

  // Operation codes. WD is shared by loads and stores; BS/BZ/HS/HZ are
  // load-only; SB/SH are store-only. 3'd7 is never legal.
  localparam logic [2:0] DM_OP_WD = 3'd0;
  localparam logic [2:0] DM_OP_BS = 3'd1;
  localparam logic [2:0] DM_OP_BZ = 3'd2;
  localparam logic [2:0] DM_OP_HS = 3'd3;
  localparam logic [2:0] DM_OP_HZ = 3'd4;
  localparam logic [2:0] DM_OP_SB = 3'd5;
  localparam logic [2:0] DM_OP_SH = 3'd6;

  localparam logic [15:0] GPIO_BASE_DEF = 16'hbf80;
  localparam logic [15:0] GLB_BASE_DEF  = 16'h8000;
  localparam logic [15:0] STK_BASE_DEF  = 16'h8003;

  localparam logic [7:0] GPIO_OFF_LED      = 8'h00;
  localparam logic [7:0] GPIO_OFF_SW       = 8'h04;
  localparam logic [7:0] GPIO_OFF_BTN      = 8'h08;
  localparam logic [7:0] GPIO_OFF_SEG_EN   = 8'h0c;
  localparam logic [7:0] GPIO_OFF_SEG_DIG  = 8'h10;
  localparam logic [7:0] GPIO_OFF_KEY      = 8'h14;
  localparam logic [7:0] GPIO_OFF_KEY_STAT = 8'h18;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_GLB  = 2'd1,
    REG_STK  = 2'd2,
    REG_GPIO = 2'd3
  } region_e;

  function automatic logic load_op_ok(input logic [2:0] op);
    return (op == DM_OP_WD) || (op == DM_OP_BS) || (op == DM_OP_BZ) ||
           (op == DM_OP_HS) || (op == DM_OP_HZ);
  endfunction

  function automatic logic store_op_ok(input logic [2:0] op);
    return (op == DM_OP_WD) || (op == DM_OP_SB) || (op == DM_OP_SH);
  endfunction

  // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary.
  function automatic logic align_ok(input logic [2:0] op, input logic [1:0] a);
    logic ok;
    ok = 1'b1;
    case (op)
      DM_OP_WD:                     ok = (a == 2'b00);
      DM_OP_HS, DM_OP_HZ, DM_OP_SH: ok = ~a[0];
      default:                      ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic gpio_off_known(input logic [7:0] off);
    return (off == GPIO_OFF_LED)    || (off == GPIO_OFF_SW)     ||
           (off == GPIO_OFF_BTN)    || (off == GPIO_OFF_SEG_EN) ||
           (off == GPIO_OFF_SEG_DIG)|| (off == GPIO_OFF_KEY)    ||
           (off == GPIO_OFF_KEY_STAT);
  endfunction

  function automatic logic gpio_off_writable(input logic [7:0] off);
    return (off == GPIO_OFF_LED) || (off == GPIO_OFF_SEG_EN) ||
           (off == GPIO_OFF_SEG_DIG);
  endfunction

endpackage

// File: rtl/periph_bus_v2_key_fifo.sv
// periph_key_fifo: small FIFO buffering keypad events.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties, clears ovf)
//   push, din  enqueue request and 4-bit key code
//   pop        dequeue request; ignored while empty
//   ovf_clr    clears the sticky overflow flag
//   head       entry at the head of the queue (meaningful when !empty)
//   count      number of stored entries, 0..DEPTH
//   empty      no entries stored
//   ovf        sticky: a push was dropped because the queue was full
//
// A pop and a push in the same cycle on a full queue free a slot first,
// so the push is accepted. An overflow set and a clear in the same cycle
// leave the flag set: the newer event wins.
module periph_key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [3:0]               din,
  input  logic                     pop,
  input  logic                     ovf_clr,
  output logic [3:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~push_ok) ovf <= 1'b1;
      else if (ovf_clr)    ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/periph_bus_v2.sv
// periph_bus_v2: CPU data-side peripheral. Decodes dm_r/dm_w accesses into
// a global-data RAM, a stack RAM and a GPIO register file.
//
// Optional feature macro: PERIPH_KEY_FIFO_EN
//   defined   -> keypad events are buffered in a KEY_DEPTH-entry FIFO
//   undefined -> KEY holds the most recent key code plus a 'seen' flag
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   dm_r, dm_w       read / write request, sampled at posedge
//   addr, wdata      byte address, store data (SB/SH use the low bits)
//   dm_op            DM_OP_* operation code
//   rdata, rvalid    load data, valid for the one cycle rvalid is high
//   err              one-cycle pulse for a rejected access
//   io_led           LED register
//   io_switch,io_btn synchronised switch and button inputs
//   key_strobe,code  keypad event pulse and key value
//   seg_en           seven-seg enable register (resets to all on)
//   seg_digits       six 4-bit digit register
//
// Handshake: a request is accepted or rejected in the cycle it is
// presented. The cycle after an accepted read rvalid=1 with rdata; the
// cycle after a rejected access err=1. Otherwise both are 0 and rdata
// keeps its last value. Byte lanes are big-endian: lane 0 is [31:24].
module periph_bus_v2
  import periph_bus_v2_pkg::*;
#(
  parameter int          N_LED     = 16,
  parameter int          N_SW      = 16,
  parameter int          N_PB      = 5,
  parameter logic [15:0] GPIO_BASE = GPIO_BASE_DEF,
  parameter logic [15:0] GLB_BASE  = GLB_BASE_DEF,
  parameter logic [15:0] STK_BASE  = STK_BASE_DEF,
  parameter int          GLB_WORDS = 1024,
  parameter int          STK_WORDS = 1024,
  parameter int          KEY_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_r,
  input  logic              dm_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        dm_op,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err,
  output logic [N_LED-1:0]  io_led,
  input  logic [N_SW-1:0]   io_switch,
  input  logic [N_PB-1:0]   io_btn,
  input  logic              key_strobe,
  input  logic [3:0]        key_code,
  output logic [5:0]        seg_en,
  output logic [23:0]       seg_digits
);

  localparam int GLB_AW = $clog2(GLB_WORDS);
  localparam int STK_AW = $clog2(STK_WORDS);

  // Lane select for loads, then sign or zero extension.
  function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                               input logic [2:0]  op,
                                               input logic [1:0]  a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[15:0] : w[31:16];
    case (op)
      DM_OP_BS: r = {{24{b[7]}}, b};
      DM_OP_BZ: r = {24'd0, b};
      DM_OP_HS: r = {{16{h[15]}}, h};
      DM_OP_HZ: r = {16'd0, h};
      default:  r = w;
    endcase
    return r;
  endfunction

  // Byte enables for stores; bit k enables lane k ([31-8k -: 8]).
  function automatic logic [3:0] lane_be(input logic [2:0] op,
                                         input logic [1:0] a);
    logic [3:0] be;
    case (op)
      DM_OP_SB: be = 4'b0001 << a;
      DM_OP_SH: be = a[1] ? 4'b1100 : 4'b0011;
      DM_OP_WD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store data so every enabled lane sees the right bits.
  function automatic logic [31:0] lane_insert(input logic [2:0]  op,
                                              input logic [31:0] d);
    logic [31:0] r;
    case (op)
      DM_OP_SB: r = {4{d[7:0]}};
      DM_OP_SH: r = {2{d[15:0]}};
      default:  r = d;
    endcase
    return r;
  endfunction

  logic [31:0]       glb_mem [GLB_WORDS];
  logic [31:0]       stk_mem [STK_WORDS];

  region_e           region;
  logic [GLB_AW-1:0] glb_idx;
  logic [STK_AW-1:0] stk_idx;
  logic              rng_ok;
  logic              op_ok;
  logic              algn_ok;
  logic              acc_ok;
  logic              rd_acc;
  logic              wr_acc;
  logic              bad_acc;
  logic [31:0]       ram_word;
  logic [31:0]       gpio_rdata;
  logic [31:0]       rd_word;
  logic [3:0]        wr_be;
  logic [31:0]       wr_lane;
  logic [31:0]       key_word;
  logic [31:0]       key_stat;
  logic              gpio_rd_key;
  logic              gpio_rd_stat;

  always_comb begin
    region  = REG_NONE;
    rng_ok  = 1'b0;
    op_ok   = 1'b0;
    algn_ok = 1'b0;
    glb_idx = addr[GLB_AW+1:2];
    stk_idx = addr[STK_AW+1:2];
    if      (addr[31:16] == GLB_BASE)  region = REG_GLB;
    else if (addr[31:16] == STK_BASE)  region = REG_STK;
    else if (addr[31:16] == GPIO_BASE) region = REG_GPIO;
    case (region)
      REG_GLB: begin
        // Any address bit above the RAM index must be zero.
        rng_ok  = (addr[15:0] >> (GLB_AW + 2)) == 16'd0;
        op_ok   = dm_w ? store_op_ok(dm_op) : load_op_ok(dm_op);
        algn_ok = align_ok(dm_op, addr[1:0]);
      end
      REG_STK: begin
        rng_ok  = (addr[15:0] >> (STK_AW + 2)) == 16'd0;
        op_ok   = dm_w ? store_op_ok(dm_op) : load_op_ok(dm_op);
        algn_ok = align_ok(dm_op, addr[1:0]);
      end
      REG_GPIO: begin
        // dm_op is ignored here; only whole-word registers exist.
        rng_ok  = (addr[15:8] == 8'd0) && gpio_off_known(addr[7:0]);
        op_ok   = ~dm_w | gpio_off_writable(addr[7:0]);
        algn_ok = (addr[1:0] == 2'b00);
      end
      default: begin
        rng_ok  = 1'b0;
        op_ok   = 1'b0;
        algn_ok = 1'b0;
      end
    endcase
    // A simultaneous read and write is never accepted.
    acc_ok = (dm_r ^ dm_w) & rng_ok & op_ok & algn_ok;
  end

  assign rd_acc  = acc_ok & dm_r;
  assign wr_acc  = acc_ok & dm_w;
  assign bad_acc = (dm_r | dm_w) & ~acc_ok;

  assign gpio_rd_key  = rd_acc && (region == REG_GPIO) && (addr[7:0] == GPIO_OFF_KEY);
  assign gpio_rd_stat = rd_acc && (region == REG_GPIO) && (addr[7:0] == GPIO_OFF_KEY_STAT);

`ifdef PERIPH_KEY_FIFO_EN
  logic [3:0]                 key_head;
  logic [$clog2(KEY_DEPTH):0] key_count;
  logic                       key_empty;
  logic                       key_ovf;

  periph_key_fifo #(
    .DEPTH (KEY_DEPTH)
  ) u_key_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (key_strobe),
    .din     (key_code),
    .pop     (gpio_rd_key),
    .ovf_clr (gpio_rd_stat),
    .head    (key_head),
    .count   (key_count),
    .empty   (key_empty),
    .ovf     (key_ovf)
  );

  // The read sees the queue before this cycle's push, so a push into an
  // empty queue alongside a read returns 0 and the new key stays queued.
  assign key_word = key_empty ? 32'd0 : {27'd0, 1'b1, key_head};
  assign key_stat = {23'd0, key_ovf, 8'(key_count)};
`else
  logic [3:0] key_last;
  logic       key_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_last <= 4'd0;
      key_seen <= 1'b0;
    end else if (key_strobe) begin
      key_last <= key_code;
      key_seen <= 1'b1;
    end
  end

  assign key_word = {27'd0, key_seen, key_last};
  assign key_stat = 32'd0;
`endif

  always_comb begin
    gpio_rdata = 32'd0;
    case (addr[7:0])
      GPIO_OFF_LED:      gpio_rdata = 32'(io_led);
      GPIO_OFF_SW:       gpio_rdata = 32'(io_switch);
      GPIO_OFF_BTN:      gpio_rdata = 32'(io_btn);
      GPIO_OFF_SEG_EN:   gpio_rdata = {26'd0, seg_en};
      GPIO_OFF_SEG_DIG:  gpio_rdata = {8'd0, seg_digits};
      GPIO_OFF_KEY:      gpio_rdata = key_word;
      GPIO_OFF_KEY_STAT: gpio_rdata = key_stat;
      default:           gpio_rdata = 32'd0;
    endcase
  end

  assign ram_word = (region == REG_STK) ? stk_mem[stk_idx] : glb_mem[glb_idx];
  assign rd_word  = (region == REG_GPIO) ? gpio_rdata
                                         : lane_extract(ram_word, dm_op, addr[1:0]);
  assign wr_be    = lane_be(dm_op, addr[1:0]);
  assign wr_lane  = lane_insert(dm_op, wdata);

  // RAM arrays carry no reset; writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc && region == REG_GLB) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) glb_mem[glb_idx][31-8*k -: 8] <= wr_lane[31-8*k -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc && region == REG_STK) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) stk_mem[stk_idx][31-8*k -: 8] <= wr_lane[31-8*k -: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata      <= 32'd0;
      rvalid     <= 1'b0;
      err        <= 1'b0;
      io_led     <= '0;
      seg_en     <= 6'h3f;
      seg_digits <= 24'd0;
    end else begin
      rvalid <= rd_acc;
      err    <= bad_acc;
      if (rd_acc) rdata <= rd_word;
      if (wr_acc && region == REG_GPIO) begin
        case (addr[7:0])
          GPIO_OFF_LED:     io_led     <= wdata[N_LED-1:0];
          GPIO_OFF_SEG_EN:  seg_en     <= wdata[5:0];
          GPIO_OFF_SEG_DIG: seg_digits <= wdata[23:0];
          default: ;
        endcase
      end
    end
  end

endmodule
